// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl: single-port data memory controller with byte/half/word access,
// fixed request-to-response latency and a valid/ready handshake on each side.
//
// Optional feature: define DMEM_MISALIGN_CHECK_EN to fault misaligned half and
// word accesses and size 3. When undefined, resp_err is tied 0, the low address
// bits are ignored for half and word accesses, and size 3 behaves as a word.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous, active-high reset
//   req_valid     request present
//   req_ready     request accepted this cycle if req_valid is also high (IDLE only)
//   req_we        1 = store, 0 = load
//   req_size      0 byte, 1 half, 2 word, 3 reserved
//   req_unsigned  loads zero-extend when 1, sign-extend when 0
//   req_addr      byte address (upper bits beyond the array wrap around)
//   req_wdata     right-aligned store data
//   resp_valid    response present, held until resp_ready
//   resp_ready    consumer accepts response
//   resp_rdata    extended load data; 0 for stores and faults
//   resp_err      access faulted
//   busy          high whenever the controller is not idle
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [31:0]         mem_q [DEPTH];

    logic [IDX_W-1:0]    idx_c;
    logic [1:0]          lane_c;
    logic [31:0]         word_c;
    logic [31:0]         byte_sh_c;
    logic [31:0]         half_sh_c;
    logic [3:0]          be_c;
    logic [31:0]         wd_rep_c;
    logic [31:0]         merged_c;
    logic [31:0]         load_c;
    logic                misalign_c;
    logic                mem_we_c;

    // Upper address bits alias onto the array (wrap-around).
    if (ADDR_W > IDX_W + 2) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr_q[ADDR_W-1:IDX_W+2];
    end

    // Datapath: lane selection, store merge, load extraction and extension.
    always_comb begin
        idx_c     = addr_q[IDX_W+1:2];
        lane_c    = addr_q[1:0];
        word_c    = mem_q[idx_c];
        byte_sh_c = word_c >> {lane_c, 3'b000};
        half_sh_c = word_c >> {lane_c[1], 4'b0000};

`ifdef DMEM_MISALIGN_CHECK_EN
        misalign_c = ((size_q == 2'd1) && addr_q[0])
                  || ((size_q == 2'd2) && (addr_q[1:0] != 2'b00))
                  || (size_q == 2'd3);
`else
        misalign_c = 1'b0;
`endif

        case (size_q)
            2'd0: begin
                be_c     = 4'b0001 << lane_c;
                wd_rep_c = {4{wdata_q[7:0]}};
                load_c   = uns_q ? {24'd0, byte_sh_c[7:0]}
                                 : {{24{byte_sh_c[7]}}, byte_sh_c[7:0]};
            end
            2'd1: begin
                be_c     = lane_c[1] ? 4'b1100 : 4'b0011;
                wd_rep_c = {2{wdata_q[15:0]}};
                load_c   = uns_q ? {16'd0, half_sh_c[15:0]}
                                 : {{16{half_sh_c[15]}}, half_sh_c[15:0]};
            end
            default: begin
                be_c     = 4'b1111;
                wd_rep_c = wdata_q;
                load_c   = word_c;
            end
        endcase

        for (int b = 0; b < 4; b++) begin
            merged_c[8*b +: 8] = be_c[b] ? wd_rep_c[8*b +: 8] : word_c[8*b +: 8];
        end
    end

    // Next-state and response logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        mem_we_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    mem_we_c     = we_q && !misalign_c;
                    rdata_d      = (we_q || misalign_c) ? 32'd0 : load_c;
                    err_d        = misalign_c;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Storage is never cleared; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && mem_we_c) begin
            mem_q[idx_c] <= merged_c;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning byte-address width.
REQ-002 SHALL have parameter DEPTH, default 128, meaning number of 32-bit words (power of 2, 4*DEPTH <= 2^ADDR_W).
REQ-003 SHALL have parameter LATENCY, default 1, meaning cycles from request acceptance to resp_valid (legal 1..8).
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  request accepted this cycle if req_valid also high.
REQ-008 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  in  2  0 byte, 1 half, 2 word, 3 reserved.
REQ-010 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-012 SHALL have port req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 SHALL have port resp_valid  out  1  response present.
REQ-014 SHALL have port resp_ready  in  1  consumer accepts response.
REQ-015 SHALL have port resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-016 SHALL have port resp_err  out  1  access faulted (see REQ-030).
REQ-017 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-019 IDLE: on req_valid && req_ready, latch we/size/unsigned/addr/wdata, load wait counter with LATENCY-1, go to ACCESS.
REQ-020 ACCESS: counter decrements each cycle; when counter = 0, perform the memory access on that edge and go to RESP.
REQ-021 resp_valid SHALL rise exactly LATENCY cycles after the acceptance edge and hold stable (rdata, err unchanged) until resp_valid && resp_ready.
REQ-022 RESP: on resp_ready go to IDLE; new request accepted no earlier than the following cycle.
REQ-023 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits ignored (wrap-around modulo 4*DEPTH bytes).
REQ-024 Store byte lanes: byte -> lane addr[1:0]; half -> lanes {1,0} if addr[1]=0 else {3,2}; word -> all four; unselected lanes unchanged.
REQ-025 Load: select byte/half by same lane rule, shift to bit 0, extend to 32 bits per req_unsigned; word returned unchanged.
REQ-026 Store to a word SHALL be visible to a load of the same word issued in the next accepted request (no stale read).
REQ-027 Memory array SHALL NOT be cleared by reset; contents undefined until written.

Reset
REQ-028 On reset: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, busy 0, req_ready 1 from the first cycle after reset deasserts.
REQ-029 Reset asserted in ACCESS before the access edge SHALL discard the pending store (memory unchanged); reset in RESP SHALL drop the response.

Configuration
REQ-030 With DMEM_MISALIGN_CHECK_EN defined: half with addr[0]=1, word with addr[1:0]!=0, or size 3 SHALL produce resp_err=1, resp_rdata=0, no memory write, same latency.
REQ-031 Without DMEM_MISALIGN_CHECK_EN: resp_err tied 0; half ignores addr[0], word ignores addr[1:0], size 3 treated as word.

Verification
REQ-032 LATENCY=1: sw 0x11223344 @0x010, then lw @0x010 -> resp_valid 1 cycle after each acceptance, rdata 0x11223344.
REQ-033 sb 0xAB @0x013 onto 0x11223344, then lb @0x013 -> 0xFFFFFFAB, lbu -> 0x000000AB, lw @0x010 -> 0xAB223344.
REQ-034 LATENCY=4, resp_ready held 0 for 3 cycles: resp_valid rises 4 cycles after acceptance, data stable, req_ready 0 until handshake done.
REQ-035 DEPTH=128: sw 0xDEADBEEF @0x204, lw @0x004 -> 0xDEADBEEF (wrap-around).
REQ-036 Macro defined: sh 0x5555 @0x011 -> resp_err 1, rdata 0, lw @0x010 unchanged; macro undefined: same sh writes lanes {1,0}, resp_err 0.
REQ-037 LATENCY=3: reset pulsed 1 cycle after sw acceptance -> resp_valid never rises, subsequent lw returns prior contents.
